// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says phase sequencer.
// Holds the state encoding, the state_dbg pin codes and the round limit.
package simon_pkg;

    localparam int unsigned MAX_ROUNDS_LIMIT = 16;
    localparam int unsigned ROUND_W          = 4;
    localparam int unsigned DBG_W            = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GEN  = 3'd1,
        ST_DISP = 3'd2,
        ST_WAIT = 3'd3,
        ST_CHK  = 3'd4,
        ST_WIN  = 3'd5,
        ST_LOSE = 3'd6
    } state_e;

    localparam logic [DBG_W-1:0] STATE_DBG_IDLE = 2'b00;
    localparam logic [DBG_W-1:0] STATE_DBG_DISP = 2'b01;
    localparam logic [DBG_W-1:0] STATE_DBG_WAIT = 2'b10;
    localparam logic [DBG_W-1:0] STATE_DBG_CHK  = 2'b11;

    // IDLE, GEN, WIN and LOSE all share the 00 pin code.
    function automatic logic [DBG_W-1:0] dbg_code(state_e s);
        case (s)
            ST_DISP: return STATE_DBG_DISP;
            ST_WAIT: return STATE_DBG_WAIT;
            ST_CHK:  return STATE_DBG_CHK;
            default: return STATE_DBG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/simon_game_ctrl_btn_edge.sv
// Start-button conditioning: 2-flop synchroniser followed by a rising-edge detector.
// The pulse is combinational off the synchronised flops; clr_i clears all three flops.
module simon_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic btn_i,
    output logic rise_c
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else if (clr_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says phase sequencer: one FSM driving start/done handshakes to the
// generate, display, wait and check blocks, plus round counter, timeout and result hold.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned RESULT_HOLD    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_rst,
    input  logic               start_btn,
    output logic               gen_start,
    input  logic               gen_done,
    output logic               disp_start,
    input  logic               disp_done,
    output logic               wait_start,
    input  logic               wait_done,
    output logic               chk_start,
    input  logic               chk_done,
    input  logic               chk_pass,
    output logic [ROUND_W-1:0] round_idx,
    output logic [DBG_W-1:0]   state_dbg,
    output logic               busy,
    output logic               game_over,
    output logic               game_won
);

    localparam int unsigned CNT_MAX    = (TIMEOUT_CYCLES > RESULT_HOLD) ? TIMEOUT_CYCLES : RESULT_HOLD;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned TO_LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int unsigned HOLD_LAST  = RESULT_HOLD - 1;
    localparam int unsigned ROUND_LAST = MAX_ROUNDS - 1;

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gen_start_q, gen_start_d;
    logic               disp_start_q, disp_start_d;
    logic               wait_start_q, wait_start_d;
    logic               chk_start_q, chk_start_d;
    logic [DBG_W-1:0]   dbg_q, dbg_d;
    logic               busy_q, busy_d;
    logic               over_q, over_d;
    logic               won_q, won_d;
    logic               start_rise_c;
    logic               first_c;

    simon_btn_edge u_btn_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (soft_rst),
        .btn_i  (start_btn),
        .rise_c (start_rise_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            round_q      <= '0;
            cnt_q        <= '0;
            gen_start_q  <= 1'b0;
            disp_start_q <= 1'b0;
            wait_start_q <= 1'b0;
            chk_start_q  <= 1'b0;
            dbg_q        <= STATE_DBG_IDLE;
            busy_q       <= 1'b0;
            over_q       <= 1'b0;
            won_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            cnt_q        <= cnt_d;
            gen_start_q  <= gen_start_d;
            disp_start_q <= disp_start_d;
            wait_start_q <= wait_start_d;
            chk_start_q  <= chk_start_d;
            dbg_q        <= dbg_d;
            busy_q       <= busy_d;
            over_q       <= over_d;
            won_q        <= won_d;
        end
    end

    // A start pulse marks the first cycle of its state; done inputs are ignored then.
    assign first_c = gen_start_q | disp_start_q | wait_start_q | chk_start_q;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        cnt_d        = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        gen_start_d  = 1'b0;
        disp_start_d = 1'b0;
        wait_start_d = 1'b0;
        chk_start_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise_c) begin
                    state_d     = ST_GEN;
                    gen_start_d = 1'b1;
                    round_d     = '0;
                end
            end
            ST_GEN: begin
                if (!first_c && gen_done) begin
                    state_d      = ST_DISP;
                    disp_start_d = 1'b1;
                end
            end
            ST_DISP: begin
                if (!first_c && disp_done) begin
                    state_d      = ST_WAIT;
                    wait_start_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            ST_WAIT: begin
                if (!first_c && wait_done) begin
                    state_d     = ST_CHK;
                    chk_start_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TO_LAST)) begin
                    state_d = ST_LOSE;
                    cnt_d   = '0;
                end
            end
            ST_CHK: begin
                if (!first_c && chk_done) begin
                    if (!chk_pass) begin
                        state_d = ST_LOSE;
                        cnt_d   = '0;
                    end else if (round_q == ROUND_W'(ROUND_LAST)) begin
                        state_d = ST_WIN;
                        cnt_d   = '0;
                    end else begin
                        state_d      = ST_DISP;
                        disp_start_d = 1'b1;
                        round_d      = round_q + ROUND_W'(1);
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (cnt_q == CNT_W'(HOLD_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (soft_rst) begin
            state_d      = ST_IDLE;
            round_d      = '0;
            cnt_d        = '0;
            gen_start_d  = 1'b0;
            disp_start_d = 1'b0;
            wait_start_d = 1'b0;
            chk_start_d  = 1'b0;
        end

        dbg_d  = dbg_code(state_d);
        busy_d = (state_d != ST_IDLE);
        over_d = (state_d == ST_WIN) || (state_d == ST_LOSE);
        won_d  = (state_d == ST_WIN);
    end

    assign gen_start  = gen_start_q;
    assign disp_start = disp_start_q;
    assign wait_start = wait_start_q;
    assign chk_start  = chk_start_q;
    assign round_idx  = round_q;
    assign state_dbg  = dbg_q;
    assign busy       = busy_q;
    assign game_over  = over_q;
    assign game_won   = won_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl: a table of whole games with expected outcomes,
// a scoreboard of expected start/result events, and a hand-written async-reset sequence.
module tb_simon_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, soft_rst, start_btn;
    logic       gen_done, disp_done, wait_done, chk_done, chk_pass;
    logic       gen_start, disp_start, wait_start, chk_start;
    logic       busy, game_over, game_won;
    logic [3:0] round_idx;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    simon_game_ctrl #(
        .MAX_ROUNDS     (3),
        .TIMEOUT_CYCLES (20),
        .RESULT_HOLD    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_rst   (soft_rst),
        .start_btn  (start_btn),
        .gen_start  (gen_start),
        .gen_done   (gen_done),
        .disp_start (disp_start),
        .disp_done  (disp_done),
        .wait_start (wait_start),
        .wait_done  (wait_done),
        .chk_start  (chk_start),
        .chk_done   (chk_done),
        .chk_pass   (chk_pass),
        .round_idx  (round_idx),
        .state_dbg  (state_dbg),
        .busy       (busy),
        .game_over  (game_over),
        .game_won   (game_won)
    );

    localparam int K_GEN = 0, K_DISP = 1, K_WAIT = 2, K_CHK = 3, K_WIN = 4, K_LOSE = 5;

    typedef struct { int kind; int rnd; } ev_t;
    typedef struct {
        string name;
        int    fail_round;   // chk_pass=0 in this round
        int    slow_round;   // round whose wait_done uses slow_delay
        int    slow_delay;   // 0 = never answer
        int    srst_round;   // soft_rst together with chk_done in this round
        int    exp_over;     // cycles with game_over=1
        int    exp_won;      // cycles with game_won=1
        int    exp_gap;      // wait_start -> chk_start/result distance in slow round (0 = skip)
        int    exp_round;    // round_idx once back in IDLE
    } game_t;

    ev_t   sb[$];
    game_t games[5];
    game_t cur;

    int checks = 0, errors = 0, cyc = 0;
    int gen_cd = -1, disp_cd = -1, wait_cd = -1, chk_cd = -1, chk_round = 0;
    int over_cnt, won_cnt, slow_gap, gen_cyc, press_cyc, last_wait_cyc;
    logic prev_over = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_check(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_round", int'(round_idx), e.rnd);
            if (kind <= K_CHK) begin
                chk("start_state_dbg", int'(state_dbg), kind);
                chk("start_busy", int'(busy), 1);
            end else begin
                chk("result_won", int'(game_won), (kind == K_WIN) ? 1 : 0);
            end
        end
    endtask

    // One clock: responders drive done pulses, then outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        gen_done  = 1'b0; disp_done = 1'b0; wait_done = 1'b0; chk_done = 1'b0;
        chk_pass  = 1'b0; soft_rst  = 1'b0;
        if (gen_cd > 0) begin gen_cd--; if (gen_cd == 0) begin gen_done = 1'b1; gen_cd = -1; end end
        if (disp_cd > 0) begin disp_cd--; if (disp_cd == 0) begin disp_done = 1'b1; disp_cd = -1; end end
        if (wait_cd > 0) begin
            wait_cd--;
            if (wait_cd == 3) disp_done = 1'b1;
            if (wait_cd == 0) begin wait_done = 1'b1; wait_cd = -1; end
        end
        if (chk_cd > 0) begin
            chk_cd--;
            if (chk_cd == 0) begin
                chk_done = 1'b1;
                chk_pass = (chk_round != cur.fail_round);
                chk_cd   = -1;
                if (chk_round == cur.srst_round) begin
                    soft_rst  = 1'b1;
                    start_btn = 1'b0;
                end
            end
        end
        if (gen_start) begin
            sb_check(K_GEN);
            chk("press_latency", cyc - press_cyc, 3);
            gen_cd = 5; gen_cyc = cyc;
            gen_done = 1'b1;
        end
        if (disp_start) begin
            sb_check(K_DISP);
            if (gen_cyc >= 0) begin chk("gen_to_disp", cyc - gen_cyc, 6); gen_cyc = -1; end
            disp_cd = 5;
        end
        if (wait_start) begin
            sb_check(K_WAIT);
            last_wait_cyc = cyc;
            if (int'(round_idx) == cur.slow_round)
                wait_cd = (cur.slow_delay == 0) ? -1 : cur.slow_delay;
            else
                wait_cd = 5;
        end
        if (chk_start) begin
            sb_check(K_CHK);
            if (int'(round_idx) == cur.slow_round) slow_gap = cyc - last_wait_cyc;
            chk_cd = 5; chk_round = int'(round_idx);
        end
        if (game_over && !prev_over) begin
            sb_check(game_won ? K_WIN : K_LOSE);
            if (int'(round_idx) == cur.slow_round) slow_gap = cyc - last_wait_cyc;
        end
        if (game_over) over_cnt++;
        if (game_won)  won_cnt++;
        prev_over = game_over;
    endtask

    task automatic push_ev(input int kind, input int rnd);
        ev_t e;
        e.kind = kind; e.rnd = rnd;
        sb.push_back(e);
    endtask

    task automatic run_game(input game_t g);
        int  n;
        bit  seen;
        cur = g;
        sb.delete();
        over_cnt = 0; won_cnt = 0; slow_gap = -1; gen_cyc = -1; last_wait_cyc = 0;
        push_ev(K_GEN, 0);
        for (int r = 0; r < 3; r++) begin
            push_ev(K_DISP, r);
            push_ev(K_WAIT, r);
            if (r == g.slow_round && g.slow_delay == 0) begin push_ev(K_LOSE, r); break; end
            push_ev(K_CHK, r);
            if (r == g.srst_round) break;
            if (r == g.fail_round) begin push_ev(K_LOSE, r); break; end
            if (r == 2) push_ev(K_WIN, r);
        end
        start_btn = 1'b1;
        press_cyc = cyc;
        seen = 1'b0;
        n = 0;
        while (n < 800 && !(seen && !busy)) begin
            tick();
            if (busy) seen = 1'b1;
            n++;
        end
        if (n >= 800) chk({g.name, "_budget"}, n, -1);
        chk({g.name, "_sb_left"}, sb.size(), 0);
        chk({g.name, "_over_cycles"}, over_cnt, g.exp_over);
        chk({g.name, "_won_cycles"}, won_cnt, g.exp_won);
        chk({g.name, "_final_round"}, int'(round_idx), g.exp_round);
        chk({g.name, "_idle_dbg"}, int'(state_dbg), 0);
        if (g.exp_gap != 0) chk({g.name, "_wait_gap"}, slow_gap, g.exp_gap);
        for (int i = 0; i < 6; i++) tick();
        start_btn = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk({g.name, "_no_restart"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        games[0] = '{"win",      -1, -1,  0, -1, 8, 8,  0, 2};
        games[1] = '{"lose_r1",   1, -1,  0, -1, 8, 0,  0, 1};
        games[2] = '{"timeout",  -1,  0,  0, -1, 8, 0, 20, 0};
        games[3] = '{"wd_at_to", -1,  0, 19, -1, 8, 8, 20, 2};
        games[4] = '{"srst_chk", -1, -1,  0,  1, 0, 0,  0, 0};
        cur = games[0];

        rst_n = 1'b0; soft_rst = 1'b0; start_btn = 1'b0;
        gen_done = 1'b0; disp_done = 1'b0; wait_done = 1'b0; chk_done = 1'b0; chk_pass = 1'b0;
        #12;
        chk("reset_outputs", int'({gen_start, disp_start, wait_start, chk_start, busy, game_over, game_won}), 0);
        chk("reset_round", int'(round_idx), 0);
        chk("reset_dbg", int'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of WAIT.
        cur = '{"rst_wait", -1, 0, 0, -1, 0, 0, 0, 0};
        sb.delete();
        push_ev(K_GEN, 0); push_ev(K_DISP, 0); push_ev(K_WAIT, 0);
        gen_cyc = -1; last_wait_cyc = -1; over_cnt = 0; won_cnt = 0; slow_gap = -1;
        start_btn = 1'b1;
        press_cyc = cyc;
        n = 0;
        while (n < 60 && last_wait_cyc < 0) begin tick(); n++; end
        chk("rst_reach_wait", int'(last_wait_cyc >= 0), 1);
        tick(); tick(); tick();
        chk("rst_pre_dbg", int'(state_dbg), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'({gen_start, disp_start, wait_start, chk_start, busy, game_over, game_won}), 0);
        chk("rst_async_dbg", int'(state_dbg), 0);
        start_btn = 1'b0;
        gen_cd = -1; disp_cd = -1; wait_cd = -1; chk_cd = -1;
        sb.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_release_dbg", int'(state_dbg), 0);
        chk("rst_release_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) tick();

        for (int g = 0; g < 5; g++) run_game(games[g]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
